mem_port_arbiter: RTL

//  Shares one single-port, fixed-latency memory between instruction fetch (IF)
//  and the load/store path driven by the MemRW decode.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the instruction-fetch request channel, the load/store request
//   channel and the memory-macro signals that the arbiter sits between.
//   slave  : the arbiter's view (takes requests and mem_rdata, drives acks,
//            read data, the memory strobe/address/data and busy)
//   master : the surrounding system's view (fetch unit, load/store unit and
//            memory macro together)
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between instruction fetch
//   and the load/store path. Each access runs IDLE -> ISSUE -> WAIT -> ACK:
//   the winner is chosen in IDLE, mem_en strobes for the single ISSUE cycle,
//   WAIT lasts MEM_LAT cycles and read data is captured on its last cycle,
//   and the winner's ack pulses for the one ACK cycle. Data normally wins a
//   tie; after STARVE_MAX consecutive data grants with fetch pending, fetch
//   is forced through. Every output comes straight from a flop.
// Ports
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset; aborts any access without ack
//   bus   : mem_port_arbiter_if.slave (fetch channel, data channel, memory)
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SCNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [WCNT_W-1:0] WAIT_INIT  = WCNT_W'(MEM_LAT - 1);
    localparam logic [SCNT_W-1:0] STARVE_LIM = SCNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state_q,      state_d;
    logic              gnt_if_q,     gnt_if_d;
    logic              gnt_d_q,      gnt_d_d;
    logic [SCNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [WCNT_W-1:0] wait_cnt_q,   wait_cnt_d;
    logic              if_ack_q,     if_ack_d;
    logic              d_ack_q,      d_ack_d;
    logic [DATA_W-1:0] if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,    d_rdata_d;
    logic              mem_en_q,     mem_en_d;
    logic              mem_we_q,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
    logic              busy_q,       busy_d;
    logic              pick_if;

    always_comb begin
        state_d      = state_q;
        gnt_if_d     = gnt_if_q;
        gnt_d_d      = gnt_d_q;
        starve_cnt_d = starve_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        busy_d       = busy_q;
        // Fetch wins only when data is idle or fetch has been starved out.
        pick_if      = bus.if_req && (!bus.d_req || (starve_cnt_q == STARVE_LIM));

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    gnt_if_d = pick_if;
                    gnt_d_d  = !pick_if;
                    mem_en_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ISSUE;
                    if (pick_if) begin
                        mem_addr_d   = bus.if_addr;
                        mem_we_d     = 1'b0;
                        starve_cnt_d = '0;
                    end else begin
                        mem_addr_d  = bus.d_addr;
                        mem_we_d    = bus.d_we;
                        mem_wdata_d = bus.d_wdata;
                        // Only a data grant that leaves fetch waiting counts
                        // toward starvation.
                        if (!bus.if_req) begin
                            starve_cnt_d = '0;
                        end else if (starve_cnt_q != STARVE_LIM) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                wait_cnt_d = WAIT_INIT;
                state_d    = WAIT;
            end
            WAIT: begin
                // mem_we stays held, so it still tells a store from a load here.
                if (wait_cnt_q == '0) begin
                    state_d = ACK;
                    if (gnt_if_q) begin
                        if_rdata_d = bus.mem_rdata;
                        if_ack_d   = 1'b1;
                    end else begin
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                        d_ack_d = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            ACK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_if_q     <= 1'b0;
            gnt_d_q      <= 1'b0;
            starve_cnt_q <= '0;
            wait_cnt_q   <= '0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_if_q     <= gnt_if_d;
            gnt_d_q      <= gnt_d_d;
            starve_cnt_q <= starve_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule
